juiz_pontos: RTL and testbench
==============================

# juiz_pontos

Point referee for the Pong datapath: watches the ball's horizontal position once per frame and detects when the ball leaves the court. On each exit it issues a one-cycle point strobe to the scoreboard. It then freezes play for a serve delay and requests a new serve from the ball engine. It also halts play permanently once the scoreboard reports a winner. It sits between the ball-motion block and the scoreboard, on the same 25 MHz clock.

## Interface
Parameters:
- `H_RES`, 640, visible court width in pixels
- `BALL_SIZE`, 8, ball width in pixels
- `X_W`, 10, width of the ball x-coordinate
- `SERVE_DELAY`, 25_000_000, clock cycles play stays frozen before a serve (1 s at 25 MHz)

Ports:
- `clock`  in  1  25 MHz system clock
- `reset`  in  1  synchronous, active-high
- `frame_tick`  in  1  one-cycle pulse per frame; `bola_x` is valid in that cycle
- `bola_x`  in  X_W  ball left-edge x-coordinate
- `ganhador`  in  2  scoreboard winner: 0 = match running, 1 or 2 = winner
- `botao_saque`  in  1  serve button, level, already synchronised
- `ponto_esquerda`  out  1  ball exited the left edge (point to right player)
- `ponto_direita`  out  1  ball exited the right edge (point to left player)
- `enable`  out  1  scoreboard write strobe, coincident with a point strobe
- `saque`  out  1  one-cycle serve request: ball engine re-centres the ball
- `saque_dir`  out  1  serve direction: 1 = toward right, 0 = toward left; valid with `saque`
- `congelar`  out  1  freeze ball motion

## Operation
- States: PAUSA, JOGO, GOL, AGUARDA, FIM.
- **PAUSA**
  - `congelar`=1; delay counter increments each cycle.
  - When the count reaches `SERVE_DELAY` and the serve condition holds (see Configuration): pulse `saque` for one cycle, clear the counter, go to JOGO.
- **JOGO**
  - `congelar`=0. Evaluated only when `frame_tick`=1.
  - `bola_x`==0 → GOL with lado=ESQ.
  - `bola_x` ≥ `H_RES`−`BALL_SIZE` → GOL with lado=DIR.
  - Both conditions true: left wins.
  - `ganhador`≠0 in any JOGO cycle → FIM; this takes priority over a goal.
- **GOL** (one cycle)
  - `enable`=1 and exactly one of `ponto_esquerda`/`ponto_direita`=1 according to lado.
  - `congelar`=1. Go to AGUARDA.
- **AGUARDA** (two cycles)
  - Gives the scoreboard time to update `ganhador`.
  - Sample `ganhador` on the last cycle: ≠0 → FIM, else → PAUSA.
  - Set `saque_dir` toward the side that conceded: lado=ESQ → 0, DIR → 1.
- **FIM**
  - `congelar`=1, no strobes. Terminal; only `reset` exits.
- Strobes never overlap. `enable` is never high without a point strobe.
- Counter width is clog2(`SERVE_DELAY`+1). It saturates at `SERVE_DELAY` while waiting for the button and never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - state=PAUSA, counter=0, `saque_dir`=1, `congelar`=1.
  - `ponto_esquerda`=`ponto_direita`=`enable`=`saque`=0.
- Reset mid-operation (including in GOL or FIM) aborts immediately. No strobe is issued in the cycle after reset.
- Goal latency:
  - Qualifying `frame_tick` in cycle n → point strobe + `enable` high in cycle n+1 only.
  - AGUARDA occupies n+2 and n+3; `ganhador` is sampled at the end of n+3.
  - PAUSA is entered at n+4.
  - With auto-serve, `saque` is high in cycle n+4+`SERVE_DELAY`.
- Once in PAUSA, `frame_tick` is ignored in PAUSA, GOL, AGUARDA and FIM, so a ball still sitting at the edge cannot re-score.
- `saque` and the JOGO entry happen on the same edge; `congelar` drops in that same cycle.

## Configuration
- Macro `JUIZ_AUTO_SERVE_EN`.
- **Defined:** the serve fires automatically when the counter reaches `SERVE_DELAY`; `botao_saque` is ignored.
- **Undefined:** after the counter reaches `SERVE_DELAY`, the block stays in PAUSA until `botao_saque`=1. `saque` then fires in the next cycle. Button presses before the delay elapses are ignored.

## Structure
- Package `juiz_pkg` holds:
  - the state enum (PAUSA, JOGO, GOL, AGUARDA, FIM);
  - the side constants ESQ=0, DIR=1;
  - the AGUARDA length constant (2).
- One sub-module, `contador_saque`:
  - parameterised by `SERVE_DELAY`;
  - inputs `clear` and `run`;
  - output `done`, which holds high while saturated.

## Test plan
All scenarios use `SERVE_DELAY`=4, `H_RES`=640, `BALL_SIZE`=8.
- Reset release with auto-serve: `congelar`=1 for 4 cycles → `saque`=1, `saque_dir`=1 in cycle 5, then `congelar`=0.
- JOGO, `frame_tick` with `bola_x`=0 at cycle n → `ponto_esquerda`=`enable`=1 in n+1 only; `saque` with `saque_dir`=0 at n+8.
- JOGO, `frame_tick` with `bola_x`=632 → `ponto_direita`=`enable`=1 for one cycle; serve later with `saque_dir`=1.
- Goal, with the bench setting `ganhador`=2 during AGUARDA → FIM: `congelar` stays 1, no `saque` for 100 cycles, and further ticks at `bola_x`=0 produce no strobes.
- Without the macro, `botao_saque` pulsed at delay cycle 2 → no serve. Pulsed at cycle 10 → `saque` at cycle 11.
- `reset` asserted in the GOL cycle → strobes drop next cycle; block returns to PAUSA with counter 0 and `saque_dir`=1.

Source files
------------

// File: rtl/juiz_pontos_pkg.sv
// Shared states and constants for the juiz_pontos point referee.
package juiz_pkg;

   typedef enum logic [2:0] {
      PAUSA,
      JOGO,
      GOL,
      AGUARDA,
      FIM
   } estado_t;

   localparam logic ESQ = 1'b0;
   localparam logic DIR = 1'b1;

   // AGUARDA gives the scoreboard this many cycles to update its winner flag
   localparam int AGUARDA_LEN = 2;
   localparam int AGUARDA_W   = (AGUARDA_LEN > 1) ? $clog2(AGUARDA_LEN) : 1;

endpackage

// File: rtl/juiz_pontos_contador_saque.sv
// Serve-delay counter: counts while run is high, saturates at SERVE_DELAY, never wraps.
module contador_saque #(
   parameter int SERVE_DELAY = 25_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic ultimo,
   output logic done
);

   localparam int            W      = $clog2(SERVE_DELAY + 1);
   localparam logic [W-1:0]  MAXIMO = W'(SERVE_DELAY);
   localparam logic [W-1:0]  PENULT = W'(SERVE_DELAY - 1);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (run && (count != MAXIMO)) begin
         count <= count + 1'b1;
      end
   end

   // ultimo flags the cycle whose increment makes the count reach SERVE_DELAY
   assign ultimo = run && (count == PENULT);
   assign done   = (count == MAXIMO);

endmodule

// File: rtl/juiz_pontos.sv
// Pong point referee: detects court exits, strobes the scoreboard, freezes play and requests serves.
// Define JUIZ_AUTO_SERVE_EN to serve automatically; otherwise serves wait for botao_saque.
module juiz_pontos
   import juiz_pkg::*;
#(
   parameter int H_RES       = 640,
   parameter int BALL_SIZE   = 8,
   parameter int X_W         = 10,
   parameter int SERVE_DELAY = 25_000_000
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           frame_tick,
   input  logic [X_W-1:0] bola_x,
   input  logic [1:0]     ganhador,
   input  logic           botao_saque,
   output logic           ponto_esquerda,
   output logic           ponto_direita,
   output logic           enable,
   output logic           saque,
   output logic           saque_dir,
   output logic           congelar
);

   localparam logic [X_W-1:0] LIMITE_DIR = X_W'(H_RES - BALL_SIZE);

   estado_t              estado;
   logic                 lado;
   logic [AGUARDA_W-1:0] espera;
   logic                 ultimo;
   logic                 done;
   logic                 pode_sacar;
   logic                 gol_esq;
   logic                 gol_dir;

   contador_saque #(
      .SERVE_DELAY(SERVE_DELAY)
   ) u_contador (
      .clock  (clock),
      .reset  (reset),
      .clear  (estado != PAUSA),
      .run    (estado == PAUSA),
      .ultimo (ultimo),
      .done   (done)
   );

`ifdef JUIZ_AUTO_SERVE_EN
   logic unused_botao;
   assign unused_botao = botao_saque;
   assign pode_sacar   = ultimo || done;
`else
   logic unused_ultimo;
   assign unused_ultimo = ultimo;
   assign pode_sacar    = done && botao_saque;
`endif

   // Left exit wins when both edges qualify (only possible with a tiny court)
   assign gol_esq = (bola_x == '0);
   assign gol_dir = !gol_esq && (bola_x >= LIMITE_DIR);

   always_ff @(posedge clock) begin
      if (reset) begin
         estado         <= PAUSA;
         lado           <= ESQ;
         espera         <= '0;
         saque_dir      <= 1'b1;
         congelar       <= 1'b1;
         ponto_esquerda <= 1'b0;
         ponto_direita  <= 1'b0;
         enable         <= 1'b0;
         saque          <= 1'b0;
      end else begin
         ponto_esquerda <= 1'b0;
         ponto_direita  <= 1'b0;
         enable         <= 1'b0;
         saque          <= 1'b0;
         case (estado)
            PAUSA: begin
               if (pode_sacar) begin
                  saque    <= 1'b1;
                  congelar <= 1'b0;
                  estado   <= JOGO;
               end
            end
            JOGO: begin
               if (ganhador != 2'd0) begin
                  congelar <= 1'b1;
                  estado   <= FIM;
               end else if (frame_tick && (gol_esq || gol_dir)) begin
                  lado           <= gol_esq ? ESQ : DIR;
                  ponto_esquerda <= gol_esq;
                  ponto_direita  <= gol_dir;
                  enable         <= 1'b1;
                  congelar       <= 1'b1;
                  estado         <= GOL;
               end
            end
            GOL: begin
               espera <= '0;
               estado <= AGUARDA;
            end
            AGUARDA: begin
               // Serve toward the side that conceded
               saque_dir <= lado;
               if (espera == AGUARDA_W'(AGUARDA_LEN - 1)) begin
                  estado <= (ganhador != 2'd0) ? FIM : PAUSA;
               end else begin
                  espera <= espera + 1'b1;
               end
            end
            FIM: begin
               estado <= FIM;
            end
            default: begin
               estado <= PAUSA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_juiz_pontos.sv
// Scoreboard bench for juiz_pontos with SERVE_DELAY=4; adapts serve timing to JUIZ_AUTO_SERVE_EN.
module tb_juiz_pontos;

   localparam int SD = 4;

   logic       clock       = 1'b0;
   logic       reset       = 1'b1;
   logic       frame_tick  = 1'b0;
   logic       botao_saque = 1'b0;
   logic [9:0] bola_x      = '0;
   logic [1:0] ganhador    = '0;
   logic       ponto_esquerda, ponto_direita, enable, saque, saque_dir, congelar;

   juiz_pontos #(
      .H_RES       (640),
      .BALL_SIZE   (8),
      .X_W         (10),
      .SERVE_DELAY (SD)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .frame_tick     (frame_tick),
      .bola_x         (bola_x),
      .ganhador       (ganhador),
      .botao_saque    (botao_saque),
      .ponto_esquerda (ponto_esquerda),
      .ponto_direita  (ponto_direita),
      .enable         (enable),
      .saque          (saque),
      .saque_dir      (saque_dir),
      .congelar       (congelar)
   );

   typedef struct {
      int   ciclo;
      logic pe;
      logic pd;
      logic en;
      logic sq;
      logic sd;
   } evento_t;

   evento_t fila[$];
   evento_t esp;
   int ciclo  = 0;
   int checks = 0;
   int passes = 0;

   always #20 clock = ~clock;
   always @(posedge clock) ciclo <= ciclo + 1;

   task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      checks++;
      if (atual === esperado) passes++;
      else $display("FAIL %s: ciclo %0d got %0d, expected %0d", nome, ciclo, atual, esperado);
   endtask

   task automatic avanca();
      @(posedge clock);
      #1;
   endtask

   task automatic confere_reset();
      verifica("reset_ponto_esquerda", ponto_esquerda, 0);
      verifica("reset_ponto_direita", ponto_direita, 0);
      verifica("reset_enable", enable, 0);
      verifica("reset_saque", saque, 0);
      verifica("reset_saque_dir", saque_dir, 1);
      verifica("reset_congelar", congelar, 1);
   endtask

   task automatic reinicia(output int r);
      reset = 1'b1;
      avanca();
      avanca();
      confere_reset();
      reset = 1'b0;
      r = ciclo;
   endtask

   // Tick in the current cycle n; a goal strobe is expected in n+1. Returns in cycle n+1.
   task automatic gol(input logic [9:0] x, input logic pe, input logic pd, output int n);
      n = ciclo;
      frame_tick = 1'b1;
      bola_x = x;
      if (pe || pd) fila.push_back('{n + 1, pe, pd, 1'b1, 1'b0, 1'b0});
      avanca();
      frame_tick = 1'b0;
   endtask

   // PAUSA entered in cycle p; waits for the serve, with a stray tick and an early button press.
   task automatic servir(input int p, input logic dir);
      int s;
`ifdef JUIZ_AUTO_SERVE_EN
      s = p + SD;
`else
      s = p + SD + 6;
`endif
      fila.push_back('{s, 1'b0, 1'b0, 1'b0, 1'b1, dir});
      while (ciclo < s) begin
         verifica("congelar_pausa", congelar, 1);
         frame_tick = (ciclo == p + 2);
         bola_x = '0;
`ifndef JUIZ_AUTO_SERVE_EN
         botao_saque = (ciclo == p + 1) || (ciclo == s - 1);
`endif
         avanca();
      end
      frame_tick = 1'b0;
      botao_saque = 1'b0;
      verifica("congelar_jogo", congelar, 0);
   endtask

   always @(negedge clock) begin
      if (ponto_esquerda || ponto_direita || enable || saque) begin
         if (fila.size() == 0) begin
            checks++;
            $display("FAIL evento_inesperado: ciclo %0d got pe=%b pd=%b en=%b saque=%b, expected no strobe",
                     ciclo, ponto_esquerda, ponto_direita, enable, saque);
         end else begin
            esp = fila.pop_front();
            verifica("evento_ciclo", ciclo, esp.ciclo);
            verifica("evento_strobes", {ponto_esquerda, ponto_direita, enable, saque},
                     {esp.pe, esp.pd, esp.en, esp.sq});
            if (esp.sq) verifica("evento_saque_dir", saque_dir, esp.sd);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: ciclo %0d got timeout, expected completion", ciclo);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      int n;
      repeat (3) avanca();
      confere_reset();
      reset = 1'b0;
      r = ciclo;
      servir(r, 1'b1);
      avanca();

      // Inside the court: no goal, including one pixel short of the right limit
      gol(10'd100, 1'b0, 1'b0, n);
      gol(10'd631, 1'b0, 1'b0, n);

      gol(10'd0, 1'b1, 1'b0, n);
      servir(n + 4, 1'b0);
      avanca();

      gol(10'd632, 1'b0, 1'b1, n);
      servir(n + 4, 1'b1);
      avanca();

      // Winner reported during AGUARDA: match ends, play stays frozen
      gol(10'd0, 1'b1, 1'b0, n);
      avanca();
      ganhador = 2'd2;
      for (int i = 0; i < 100; i++) begin
         verifica("congelar_fim", congelar, 1);
         frame_tick = (i % 10 == 0);
         bola_x = '0;
         botao_saque = (i % 10 == 5);
         avanca();
      end
      frame_tick = 1'b0;
      botao_saque = 1'b0;
      ganhador = 2'd0;

      reinicia(r);
      servir(r, 1'b1);
      avanca();
      gol(10'd0, 1'b1, 1'b0, n);
      servir(n + 4, 1'b0);
      avanca();

      // Reset during the GOL cycle
      gol(10'd0, 1'b1, 1'b0, n);
      reset = 1'b1;
      avanca();
      verifica("reset_gol_ponto_esquerda", ponto_esquerda, 0);
      verifica("reset_gol_enable", enable, 0);
      verifica("reset_gol_saque_dir", saque_dir, 1);
      verifica("reset_gol_congelar", congelar, 1);
      reset = 1'b0;
      r = ciclo;
      servir(r, 1'b1);
      avanca();

      // Winner seen in JOGO beats a simultaneous goal
      ganhador = 2'd1;
      gol(10'd0, 1'b0, 1'b0, n);
      for (int i = 0; i < 20; i++) begin
         verifica("congelar_fim_jogo", congelar, 1);
         frame_tick = 1'b1;
         bola_x = '0;
         avanca();
      end
      frame_tick = 1'b0;

      for (int i = 0; i < 50 && fila.size() > 0; i++) avanca();
      while (fila.size() > 0) begin
         esp = fila.pop_front();
         checks++;
         $display("FAIL evento_ausente: got nothing, expected strobe at ciclo %0d (pe=%b pd=%b saque=%b)",
                  esp.ciclo, esp.pe, esp.pd, esp.sq);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
